// File: rtl/ahb_arbiter_pkg.sv
// ahb_arbiter_pkg
//   Shared types for the AHB arbiter: AHB transfer/burst encodings, the
//   arbiter FSM state and a helper that maps hburst to its beat count.
//   Optional feature macro used by this block: AHB_ARB_TIMEOUT_EN.
package ahb_arbiter_pkg;

    typedef enum logic [1:0] {
        HT_IDLE   = 2'b00,
        HT_BUSY   = 2'b01,
        HT_NONSEQ = 2'b10,
        HT_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        HB_SINGLE = 3'd0,
        HB_INCR   = 3'd1,
        HB_WRAP4  = 3'd2,
        HB_INCR4  = 3'd3,
        HB_WRAP8  = 3'd4,
        HB_INCR8  = 3'd5,
        HB_WRAP16 = 3'd6,
        HB_INCR16 = 3'd7
    } hburst_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OWN,
        ST_BURST,
        ST_LOCK
    } arb_state_t;

    // Fixed-length bursts report their length; SINGLE and undefined-length
    // INCR report 1 so they never hold the bus.
    function automatic logic [4:0] burst_beats(input hburst_t b);
        case (b)
            HB_WRAP4,  HB_INCR4:  burst_beats = 5'd4;
            HB_WRAP8,  HB_INCR8:  burst_beats = 5'd8;
            HB_WRAP16, HB_INCR16: burst_beats = 5'd16;
            default:              burst_beats = 5'd1;
        endcase
    endfunction

endpackage

// File: rtl/ahb_arbiter_if.sv
// ahb_arbiter_if
//   Arbitration bus between the masters and the arbiter.
//   master modport : drives hreq/hlock/prio/htrans/hburst/hready, sees grant
//   slave modport  : the arbiter side (consumes requests, drives
//                    hgrant/hmaster/hmastlock/hold_tout)
interface ahb_arbiter_if #(
    parameter int MAS_NUM  = 4,
    parameter int PRIORBIT = 2
);
    import ahb_arbiter_pkg::*;

    localparam int MW = $clog2(MAS_NUM);

    logic [MAS_NUM-1:0]          hreq;
    logic [MAS_NUM-1:0]          hlock;
    logic [MAS_NUM*PRIORBIT-1:0] prio;
    htrans_t                     htrans;
    hburst_t                     hburst;
    logic                        hready;
    logic [MAS_NUM-1:0]          hgrant;
    logic [MW-1:0]               hmaster;
    logic                        hmastlock;
    logic                        hold_tout;

    modport master (
        output hreq, hlock, prio, htrans, hburst, hready,
        input  hgrant, hmaster, hmastlock, hold_tout
    );

    modport slave (
        input  hreq, hlock, prio, htrans, hburst, hready,
        output hgrant, hmaster, hmastlock, hold_tout
    );

endinterface

// File: rtl/ahb_arb_pick.sv
// ahb_arb_pick
//   Combinational winner selection.
//   req_i    : request vector          prio_i  : packed per-master priority
//   rr_ptr_i : last round-robin winner excl_i  : masters barred this round
//   winner_o : highest priority requester; ties go to the first one found
//              scanning upward from rr_ptr_i+1 (wrapping); DEF_MASTER if none.
module ahb_arb_pick #(
    parameter int MAS_NUM    = 4,
    parameter int PRIORBIT   = 2,
    parameter int DEF_MASTER = 0,
    localparam int IW        = $clog2(MAS_NUM)
) (
    input  logic [MAS_NUM-1:0]          req_i,
    input  logic [MAS_NUM*PRIORBIT-1:0] prio_i,
    input  logic [IW-1:0]               rr_ptr_i,
    input  logic [MAS_NUM-1:0]          excl_i,
    output logic [IW-1:0]               winner_o
);

    logic [PRIORBIT-1:0] pr [MAS_NUM];

    for (genvar i = 0; i < MAS_NUM; i++) begin : g_unpack
        assign pr[i] = prio_i[i*PRIORBIT +: PRIORBIT];
    end

    always_comb begin
        logic [MAS_NUM-1:0]  cand;
        logic                found;
        logic [PRIORBIT-1:0] best;
        logic [IW-1:0]       idx;
        cand     = req_i & ~excl_i;
        found    = 1'b0;
        best     = '0;
        idx      = '0;
        winner_o = IW'(DEF_MASTER);
        // Strict '>' keeps the earliest candidate in scan order on a tie,
        // which is what makes equal priorities rotate.
        for (int k = 1; k <= MAS_NUM; k++) begin
            idx = IW'((int'(rr_ptr_i) + k) % MAS_NUM);
            if (cand[idx] && (!found || pr[idx] > best)) begin
                found    = 1'b1;
                best     = pr[idx];
                winner_o = idx;
            end
        end
    end

endmodule

// File: rtl/ahb_arbiter.sv
// ahb_arbiter
//   Shares one AHB bus among MAS_NUM masters. Priority pick with round-robin
//   among equals; grant is held through fixed-length bursts and locked
//   sequences. All outputs are registered and advance only when hready=1.
//   Ports: hclk, hreset (sync, active-high), bus (ahb_arbiter_if.slave).
//   Macro AHB_ARB_TIMEOUT_EN: builds hold_cnt and forces release of a
//   burst/lock owner after MAX_HOLD cycles of others waiting (hold_tout).
module ahb_arbiter
    import ahb_arbiter_pkg::*;
#(
    parameter int MAS_NUM    = 4,
    parameter int PRIORBIT   = 2,
    parameter int DEF_MASTER = 0,
    parameter int MAX_HOLD   = 64
) (
    input logic          hclk,
    input logic          hreset,
    ahb_arbiter_if.slave bus
);

    localparam int                 IW      = $clog2(MAS_NUM);
    localparam logic [MAS_NUM-1:0] DEF_GNT = MAS_NUM'(1) << DEF_MASTER;

    arb_state_t         state_q, state_d;
    logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [3:0]         beat_cnt_q, beat_cnt_d;
    logic [MAS_NUM-1:0] hgrant_q, hgrant_d;
    logic [IW-1:0]      hmaster_q;
    logic               hmastlock_q;
    logic               hold_tout_d;
    logic               arb;
    logic               force_rel;
    logic [MAS_NUM-1:0] excl;
    logic [IW-1:0]      winner;
    logic [IW-1:0]      owner;

    ahb_arb_pick #(
        .MAS_NUM   (MAS_NUM),
        .PRIORBIT  (PRIORBIT),
        .DEF_MASTER(DEF_MASTER)
    ) u_pick (
        .req_i   (bus.hreq),
        .prio_i  (bus.prio),
        .rr_ptr_i(rr_ptr_q),
        .excl_i  (excl),
        .winner_o(winner)
    );

    // Grant owner index (the master that hmaster will follow next phase).
    always_comb begin
        owner = '0;
        for (int i = 0; i < MAS_NUM; i++)
            if (hgrant_q[i]) owner = IW'(i);
    end

`ifdef AHB_ARB_TIMEOUT_EN
    localparam int HW = $clog2(MAX_HOLD + 1);

    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          hold_tout_q;

    assign force_rel = (hold_cnt_q == HW'(MAX_HOLD)) &&
                       (state_q == ST_LOCK || state_q == ST_BURST);

    // Saturating count of owner cycles with someone else waiting.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (hgrant_d != hgrant_q)
            hold_cnt_d = '0;
        else if (|(bus.hreq & ~hgrant_q) && hold_cnt_q != HW'(MAX_HOLD))
            hold_cnt_d = hold_cnt_q + 1'b1;
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            hold_cnt_q  <= '0;
            hold_tout_q <= 1'b0;
        end else if (bus.hready) begin
            hold_cnt_q  <= hold_cnt_d;
            hold_tout_q <= hold_tout_d;
        end
    end

    assign bus.hold_tout = hold_tout_q;
`else
    logic unused_cfg;

    assign force_rel     = 1'b0;
    assign bus.hold_tout = 1'b0;
    assign unused_cfg    = (MAX_HOLD == 0) | hold_tout_d;
`endif

    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        arb         = 1'b0;
        excl        = '0;
        hold_tout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                arb = 1'b1;
                if (|bus.hreq) state_d = ST_OWN;
            end
            ST_OWN: begin
                // A burst start pins the grant, so it wins over re-arbitration.
                if (bus.htrans == HT_NONSEQ && burst_beats(bus.hburst) > 5'd1) begin
                    state_d    = ST_BURST;
                    beat_cnt_d = 4'(burst_beats(bus.hburst) - 5'd1);
                end else if (bus.hlock[owner]) begin
                    state_d = ST_LOCK;
                end else begin
                    arb = 1'b1;
                    if (!(|bus.hreq)) state_d = ST_IDLE;
                end
            end
            ST_BURST: begin
                if (bus.htrans == HT_SEQ) begin
                    if (beat_cnt_q == '0) begin
                        state_d = ST_OWN;
                        arb     = 1'b1;
                    end else begin
                        beat_cnt_d = beat_cnt_q - 1'b1;
                    end
                end else if (bus.htrans != HT_BUSY) begin
                    // IDLE or NONSEQ mid-burst: burst was cut short.
                    beat_cnt_d = '0;
                    state_d    = ST_OWN;
                end
            end
            ST_LOCK: begin
                if (!bus.hlock[owner]) state_d = ST_OWN;
            end
            default: state_d = ST_IDLE;
        endcase
        if (force_rel) begin
            state_d     = ST_OWN;
            beat_cnt_d  = '0;
            arb         = 1'b1;
            excl        = hgrant_q;
            hold_tout_d = 1'b1;
        end
    end

    assign hgrant_d = arb ? (MAS_NUM'(1) << winner) : hgrant_q;
    assign rr_ptr_d = (arb && bus.hreq[winner]) ? winner : rr_ptr_q;

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= IW'(DEF_MASTER);
            beat_cnt_q  <= '0;
            hgrant_q    <= DEF_GNT;
            hmaster_q   <= IW'(DEF_MASTER);
            hmastlock_q <= 1'b0;
        end else if (bus.hready) begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            beat_cnt_q  <= beat_cnt_d;
            hgrant_q    <= hgrant_d;
            hmaster_q   <= owner;
            hmastlock_q <= bus.hlock[hmaster_q];
        end
    end

    assign bus.hgrant    = hgrant_q;
    assign bus.hmaster   = hmaster_q;
    assign bus.hmastlock = hmastlock_q;

endmodule
